data_ld_stream: RTL and testbench
=================================

Name: data_ld_stream

Overview:
- Parametrised successor to the regression sample loader.
- Accepts a variable-length stream of (x,y) sample pairs and stores them in an internal buffer.
- Replays the buffer once to the coefficient unit, then optionally once to the error unit, handshaking with each unit's done signal.
- Sits between the sample source and the coef/err datapaths in the linear-regression core.

Parameters:
- DW, 20, width of each x and y sample in bits
- DEPTH, 150, maximum samples stored; must be ≥2
- ERR_PASS, 1, 1 = run the error replay pass after the coefficient pass; 0 = skip it
- AW, $clog2(DEPTH), derived buffer address width; not to be overridden

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begins a load; honoured only in IDLE
- in_valid  in  1  inx/iny carry a valid sample
- in_last  in  1  qualifies the final sample of the stream
- inx  in  DW  sample x
- iny  in  DW  sample y
- in_ready  out  1  loader can accept a sample this cycle
- outx  out  DW  replayed x (registered)
- outy  out  DW  replayed y (registered)
- out_valid  out  1  outx/outy valid this cycle
- out_last  out  1  outx/outy is the last stored sample
- coef_done  in  1  coefficient unit finished consuming the pass
- err_done  in  1  error unit finished consuming the pass
- en_coef  out  1  coefficient pass active
- en_err  out  1  error pass active
- finishd  out  1  one-cycle pulse when all passes are complete
- cout  out  1  one-cycle pulse when the buffer fills to DEPTH during a load
- num_samples  out  AW+1  samples captured in the last load
- con_state  out  3  current FSM state code

Behaviour:
- Reset: async on rst high. state=IDLE and every output=0, including num_samples; pointers cleared. Buffer contents are not reset.
- States and codes: IDLE=0, LOAD=1, COEF_RD=2, COEF_WAIT=3, ERR_RD=4, ERR_WAIT=5, DONE=6.
- IDLE: start=1 → LOAD next cycle; wr_ptr and count cleared.
- LOAD:
  - in_ready=1 while count<DEPTH.
  - Each in_valid&in_ready cycle writes {inx,iny} at wr_ptr and increments count.
  - Leave to COEF_RD when the accepted sample has in_last=1, or when count reaches DEPTH.
  - Reaching DEPTH pulses cout for 1 cycle; this also applies when in_last coincides with the DEPTH-th sample.
  - in_valid with in_ready=0 is dropped with no effect.
  - num_samples is updated on LOAD exit.
  - in_last without in_valid is ignored.
- COEF_RD:
  - en_coef=1.
  - Issues addresses 0..count-1, one per cycle.
  - Synchronous buffer read: outx/outy/out_valid appear 1 cycle after the address is issued.
  - out_last is asserted with data from address count-1.
  - After issuing the last address → COEF_WAIT.
- COEF_WAIT:
  - en_coef stays 1; out_valid for the final word is still emitted in the first cycle here.
  - coef_done=1 → ERR_RD if ERR_PASS=1, else DONE.
  - coef_done is ignored in all other states.
- ERR_RD / ERR_WAIT: identical to COEF_RD/COEF_WAIT, using en_err and err_done. err_done is honoured only in ERR_WAIT.
- DONE: finishd=1 for exactly 1 cycle → IDLE. num_samples holds until the next LOAD exit.
- start outside IDLE is ignored.
- coef_done and err_done asserted on the same cycle in COEF_WAIT: only coef_done acts.
- Single-sample stream: in_last on the first sample → one replay word with out_valid and out_last together.
- rst mid-pass: immediate return to IDLE; en_* and out_valid drop asynchronously.
- out_valid/out_last are 0 whenever no read was issued on the previous cycle.

Decomposition:
- Shared package holds:
  - the state enum/localparams for IDLE..DONE (3-bit), reused by con_state decoders in the top level;
  - the default DW=20.
- One natural sub-module: sample_buf, a simple dual-port synchronous RAM (DEPTH × 2·DW, registered read, no reset on storage).
- FSM, pointers and count stay in data_ld_stream.

Test Plan:
- Basic load, DW=20, DEPTH=8: start, 5 samples x=1..5, y=10..50, last on the 5th:
  - num_samples=5, cout never pulses;
  - COEF_RD emits (1,10)..(5,50) on consecutive cycles, out_last on (5,50);
  - coef_done → identical ERR pass;
  - err_done → finishd pulses 1 cycle, con_state returns to 0.
- Overflow, DEPTH=8: 10 back-to-back samples, no in_last:
  - cout pulses on the 8th accept, in_ready=0 from the next cycle;
  - samples 9–10 dropped, num_samples=8, replay ends at sample 8.
- ERR_PASS=0: 3 samples, then coef_done → DONE directly. en_err never asserts; finishd pulses once.
- Handshake robustness:
  - coef_done held high during COEF_RD has no effect;
  - start pulsed during COEF_WAIT is ignored;
  - err_done in COEF_WAIT is ignored.
- Single sample plus gaps: x=7, y=9 with in_last, in_valid toggling low before it → one replay word with out_valid=out_last=1.
- Reset mid-replay: assert rst during the 2nd output word of a 6-sample COEF_RD:
  - all outputs 0 immediately, con_state=0;
  - a new start and load of 2 samples replays only those 2 samples.

Source files
------------

// File: rtl/data_ld_stream_pkg.sv
// rtl/data_ld_stream_pkg.sv - shared state codes and defaults for the sample loader
package data_ld_stream_pkg;

   localparam int DEFAULT_DW = 20;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_COEF_RD   = 3'd2,
      ST_COEF_WAIT = 3'd3,
      ST_ERR_RD    = 3'd4,
      ST_ERR_WAIT  = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

endpackage

// File: rtl/data_ld_stream_sample_buf.sv
// rtl/data_ld_stream_sample_buf.sv - simple dual-port sample RAM with registered read
module sample_buf #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 150,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Storage is intentionally left unreset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/data_ld_stream.sv
// rtl/data_ld_stream.sv - loads a sample stream into a buffer and replays it to the coef/err units
module data_ld_stream
   import data_ld_stream_pkg::*;
#(
   parameter int DW       = DEFAULT_DW,
   parameter int DEPTH    = 150,
   parameter int ERR_PASS = 1,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          in_valid,
   input  logic          in_last,
   input  logic [DW-1:0] inx,
   input  logic [DW-1:0] iny,
   output logic          in_ready,
   output logic [DW-1:0] outx,
   output logic [DW-1:0] outy,
   output logic          out_valid,
   output logic          out_last,
   input  logic          coef_done,
   input  logic          err_done,
   output logic          en_coef,
   output logic          en_err,
   output logic          finishd,
   output logic          cout,
   output logic [AW:0]   num_samples,
   output logic [2:0]    con_state
);

   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   state_t          state, state_nxt;
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;
   logic            accept, full_hit, last_addr, rd_en;
   logic [2*DW-1:0] rd_data;

   assign accept    = in_valid & in_ready;
   assign full_hit  = accept && (count == DEPTH_C - 1'b1);
   assign last_addr = ({1'b0, rd_ptr} == count - 1'b1);
   assign cout      = full_hit;
   assign con_state = state;

   // Data is masked by out_valid so the unreset RAM output never leaks out.
   assign outx = out_valid ? rd_data[2*DW-1:DW] : '0;
   assign outy = out_valid ? rd_data[DW-1:0]    : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (start) state_nxt = ST_LOAD;
         ST_LOAD:      if (accept && (in_last || full_hit)) state_nxt = ST_COEF_RD;
         ST_COEF_RD:   if (last_addr) state_nxt = ST_COEF_WAIT;
         ST_COEF_WAIT: begin
            if (coef_done) begin
               if (ERR_PASS != 0) state_nxt = ST_ERR_RD;
               else               state_nxt = ST_DONE;
            end
         end
         ST_ERR_RD:    if (last_addr) state_nxt = ST_ERR_WAIT;
         ST_ERR_WAIT:  if (err_done) state_nxt = ST_DONE;
         ST_DONE:      state_nxt = ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      rd_en    = 1'b0;
      en_coef  = 1'b0;
      en_err   = 1'b0;
      finishd  = 1'b0;
      case (state)
         ST_LOAD:      in_ready = (count < DEPTH_C);
         ST_COEF_RD:   begin en_coef = 1'b1; rd_en = 1'b1; end
         ST_COEF_WAIT: en_coef = 1'b1;
         ST_ERR_RD:    begin en_err = 1'b1; rd_en = 1'b1; end
         ST_ERR_WAIT:  en_err = 1'b1;
         ST_DONE:      finishd = 1'b1;
         default:      ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         num_samples <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
      end else begin
         out_valid <= rd_en;
         out_last  <= rd_en & last_addr;
         if (state == ST_IDLE && start) begin
            wr_ptr <= '0;
            count  <= '0;
            rd_ptr <= '0;
         end
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
         end
         // Every LOAD exit coincides with an accepted sample.
         if (state == ST_LOAD && state_nxt == ST_COEF_RD) num_samples <= count + 1'b1;
         if (rd_en) rd_ptr <= last_addr ? '0 : rd_ptr + 1'b1;
      end
   end

   sample_buf #(
      .WIDTH (2*DW),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_buf (
      .clk     (clk),
      .wr_en   (accept),
      .wr_addr (wr_ptr),
      .wr_data ({inx, iny}),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_data_ld_stream.sv
// tb/tb_data_ld_stream.sv - directed bench for data_ld_stream (DEPTH=8, both ERR_PASS settings)
module tb_data_ld_stream;

   logic        clk = 1'b0;
   logic        rst, start0, start1, in_valid, in_last, coef_done, err_done;
   logic [19:0] inx, iny;

   logic        in_ready, out_valid, out_last, en_coef, en_err, finishd, cout;
   logic [19:0] outx, outy;
   logic [3:0]  num_samples;
   logic [2:0]  con_state;

   logic        in_ready_1, out_valid_1, out_last_1, en_coef_1, en_err_1, finishd_1, cout_1;
   logic [19:0] outx_1, outy_1;
   logic [3:0]  num_samples_1;
   logic [2:0]  con_state_1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_ld_stream #(.DW(20), .DEPTH(8), .ERR_PASS(1)) dut0 (
      .clk(clk), .rst(rst), .start(start0), .in_valid(in_valid), .in_last(in_last),
      .inx(inx), .iny(iny), .in_ready(in_ready), .outx(outx), .outy(outy),
      .out_valid(out_valid), .out_last(out_last), .coef_done(coef_done), .err_done(err_done),
      .en_coef(en_coef), .en_err(en_err), .finishd(finishd), .cout(cout),
      .num_samples(num_samples), .con_state(con_state)
   );

   data_ld_stream #(.DW(20), .DEPTH(8), .ERR_PASS(0)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid), .in_last(in_last),
      .inx(inx), .iny(iny), .in_ready(in_ready_1), .outx(outx_1), .outy(outy_1),
      .out_valid(out_valid_1), .out_last(out_last_1), .coef_done(coef_done), .err_done(err_done),
      .en_coef(en_coef_1), .en_err(en_err_1), .finishd(finishd_1), .cout(cout_1),
      .num_samples(num_samples_1), .con_state(con_state_1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic begin_load(input bit which);
      if (which) start1 = 1'b1; else start0 = 1'b1;
      tick();
      start0 = 1'b0;
      start1 = 1'b0;
      chk("enter_load", which ? con_state_1 : con_state, 32'd1);
   endtask

   task automatic load_seq(input bit which, input int n, input int xb, input int xs,
                           input int yb, input int ys);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_last  = (i == n - 1);
         inx      = 20'(xb + i * xs);
         iny      = 20'(yb + i * ys);
         #1;
         chk("load_ready", which ? in_ready_1 : in_ready, 32'd1);
         tick();
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("load_exit_state", which ? con_state_1 : con_state, 32'd2);
      chk("num_samples", which ? num_samples_1 : num_samples, 32'(n));
   endtask

   task automatic check_replay(input bit which, input int n, input int xb, input int xs,
                               input int yb, input int ys, input int wait_code);
      for (int k = 0; k < n; k++) begin
         tick();
         chk("rep_valid", which ? out_valid_1 : out_valid, 32'd1);
         chk("rep_x", which ? outx_1 : outx, 32'(xb + k * xs));
         chk("rep_y", which ? outy_1 : outy, 32'(yb + k * ys));
         chk("rep_last", which ? out_last_1 : out_last, 32'(k == n - 1));
      end
      chk("rep_wait_state", which ? con_state_1 : con_state, 32'(wait_code));
   endtask

   task automatic wait_state0(input logic [2:0] tgt, input string tag);
      int n = 0;
      while (con_state !== tgt && n < 50) begin
         tick();
         n++;
      end
      chk(tag, con_state, 32'(tgt));
   endtask

   // Takes dut0 from COEF_WAIT through the error pass back to IDLE.
   task automatic drain0;
      coef_done = 1'b1;
      tick();
      coef_done = 1'b0;
      wait_state0(3'd5, "drain_err_wait");
      err_done = 1'b1;
      tick();
      err_done = 1'b0;
      chk("drain_finishd", finishd, 32'd1);
      tick();
      chk("drain_idle", con_state, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start0 = 0; start1 = 0; in_valid = 0; in_last = 0;
      coef_done = 0; err_done = 0; inx = '0; iny = '0;
      tick(); tick();
      chk("rst_state", con_state, 32'd0);
      chk("rst_out_valid", out_valid, 32'd0);
      chk("rst_en_coef", en_coef, 32'd0);
      chk("rst_num_samples", num_samples, 32'd0);
      chk("rst_in_ready", in_ready, 32'd0);
      chk("rst_outx", outx, 32'd0);
      rst = 1'b0;
      tick();

      // basic load of 5 samples, coef pass then err pass
      begin_load(0);
      for (int i = 1; i <= 5; i++) begin
         in_valid = 1'b1; in_last = (i == 5); inx = 20'(i); iny = 20'(10 * i);
         #1;
         chk("basic_cout", cout, 32'd0);
         tick();
      end
      in_valid = 1'b0; in_last = 1'b0;
      chk("basic_coef_rd", con_state, 32'd2);
      chk("basic_num", num_samples, 32'd5);
      chk("basic_no_valid_yet", out_valid, 32'd0);
      chk("basic_en_coef", en_coef, 32'd1);
      check_replay(0, 5, 1, 1, 10, 10, 3);
      chk("basic_wait_en_coef", en_coef, 32'd1);
      tick();
      chk("basic_valid_drop", out_valid, 32'd0);
      coef_done = 1'b1;
      tick();
      coef_done = 1'b0;
      chk("basic_err_rd", con_state, 32'd4);
      chk("basic_en_err", en_err, 32'd1);
      chk("basic_en_coef_off", en_coef, 32'd0);
      check_replay(0, 5, 1, 1, 10, 10, 5);
      err_done = 1'b1;
      tick();
      err_done = 1'b0;
      chk("basic_done", con_state, 32'd6);
      chk("basic_finishd", finishd, 32'd1);
      tick();
      chk("basic_finishd_once", finishd, 32'd0);
      chk("basic_idle", con_state, 32'd0);
      chk("basic_num_hold", num_samples, 32'd5);

      // overflow: 10 samples offered, only 8 stored
      begin_load(0);
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_last = 1'b0; inx = 20'(100 + i); iny = 20'(200 + i);
         #1;
         chk("ovf_ready", in_ready, 32'd1);
         chk("ovf_cout", cout, 32'(i == 8));
         tick();
      end
      chk("ovf_state", con_state, 32'd2);
      chk("ovf_num", num_samples, 32'd8);
      inx = 20'd109; iny = 20'd209;
      #1;
      chk("ovf_not_ready", in_ready, 32'd0);
      chk("ovf_cout_once", cout, 32'd0);
      for (int k = 0; k < 8; k++) begin
         if (k == 1) begin inx = 20'd110; iny = 20'd210; end
         if (k == 2) in_valid = 1'b0;
         tick();
         chk("ovf_rep_valid", out_valid, 32'd1);
         chk("ovf_rep_x", outx, 32'(101 + k));
         chk("ovf_rep_y", outy, 32'(201 + k));
         chk("ovf_rep_last", out_last, 32'(k == 7));
      end
      chk("ovf_wait", con_state, 32'd3);
      drain0();

      // ERR_PASS=0 instance goes straight to DONE
      begin_load(1);
      load_seq(1, 3, 1, 1, 2, 2);
      check_replay(1, 3, 1, 1, 2, 2, 3);
      coef_done = 1'b1;
      tick();
      coef_done = 1'b0;
      chk("nerr_done", con_state_1, 32'd6);
      chk("nerr_finishd", finishd_1, 32'd1);
      chk("nerr_en_err", en_err_1, 32'd0);
      tick();
      chk("nerr_finishd_once", finishd_1, 32'd0);
      chk("nerr_idle", con_state_1, 32'd0);
      chk("nerr_en_err_idle", en_err_1, 32'd0);

      // handshake robustness
      begin_load(0);
      load_seq(0, 2, 3, 2, 4, 2);
      coef_done = 1'b1;
      tick();
      chk("hs_coef_done_in_rd", con_state, 32'd2);
      tick();
      coef_done = 1'b0;
      chk("hs_wait", con_state, 32'd3);
      start0 = 1'b1; err_done = 1'b1;
      tick();
      start0 = 1'b0; err_done = 1'b0;
      chk("hs_start_err_ignored", con_state, 32'd3);
      coef_done = 1'b1; err_done = 1'b1;
      tick();
      coef_done = 1'b0; err_done = 1'b0;
      chk("hs_coef_wins", con_state, 32'd4);
      check_replay(0, 2, 3, 2, 4, 2, 5);
      err_done = 1'b1;
      tick();
      err_done = 1'b0;
      chk("hs_finishd", finishd, 32'd1);
      tick();

      // single sample with gaps and a stray in_last
      begin_load(0);
      in_valid = 1'b0; in_last = 1'b1; inx = 20'd99; iny = 20'd98;
      tick();
      chk("single_still_load", con_state, 32'd1);
      in_valid = 1'b1; in_last = 1'b1; inx = 20'd7; iny = 20'd9;
      tick();
      in_valid = 1'b0; in_last = 1'b0;
      chk("single_num", num_samples, 32'd1);
      check_replay(0, 1, 7, 0, 9, 0, 3);
      tick();
      chk("single_valid_drop", out_valid, 32'd0);
      drain0();

      // reset during the second replayed word
      begin_load(0);
      load_seq(0, 6, 21, 1, 41, 1);
      tick();
      tick();
      chk("mid_word2_x", outx, 32'd22);
      rst = 1'b1;
      #1;
      chk("mid_rst_state", con_state, 32'd0);
      chk("mid_rst_valid", out_valid, 32'd0);
      chk("mid_rst_en_coef", en_coef, 32'd0);
      chk("mid_rst_outx", outx, 32'd0);
      chk("mid_rst_num", num_samples, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      begin_load(0);
      load_seq(0, 2, 60, 2, 61, 2);
      check_replay(0, 2, 60, 2, 61, 2, 3);
      tick();
      chk("mid_reload_valid_drop", out_valid, 32'd0);
      drain0();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
